// File: rtl/lsu_mem_if_if.sv
// Data-memory request/grant/response bus between the LSU and data memory.
interface lsu_mem_if_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_mem_if.sv
// RV32 MEM-stage load/store memory interface: req/gnt/rvalid handshake.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with a misalign pulse.
module lsu_mem_if #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_width,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          lsu_busy,
    output logic          ld_valid,
    output logic [DW-1:0] ld_data_raw,
    output logic [2:0]    ld_width,
    output logic          st_done,
    output logic          misalign,
    lsu_mem_if_if.master  dm
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  width_q;
    logic [1:0]  off_q;
    logic        accept;
    logic        trap;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign accept   = (state == IDLE) || (state == DONE);
    assign lsu_busy = (req_valid && accept) || (state == REQ) || (state == WAIT);

    // Offset is forced to natural alignment; trapped requests never use it.
    always_comb begin
        is_byte = (req_width[1:0] == 2'b00);
        is_half = (req_width[1:0] == 2'b01);
        is_word = (req_width == 3'b010);
        off     = req_addr[1:0];
        if (is_half) off[0] = 1'b0;
        if (is_word) off = 2'b00;
        be    = 4'b1111;
        wdata = req_wdata;
        unique case (1'b1)
            is_byte: begin
                be    = 4'b0001 << off;
                wdata = {4{req_wdata[7:0]}};
            end
            is_half: begin
                be    = 4'b0011 << off;
                wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (is_half && req_addr[0])
               || (is_word && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= req_valid && accept && trap;
    end
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            width_q     <= 3'b000;
            off_q       <= 2'b00;
            dm.req      <= 1'b0;
            dm.we       <= 1'b0;
            dm.addr     <= '0;
            dm.be       <= 4'b0000;
            dm.wdata    <= '0;
            ld_valid    <= 1'b0;
            st_done     <= 1'b0;
            ld_data_raw <= '0;
            ld_width    <= 3'b000;
        end else begin
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (req_valid && trap) begin
                        state <= DONE;
                    end else if (req_valid) begin
                        state    <= REQ;
                        we_q     <= req_we;
                        width_q  <= req_width;
                        off_q    <= off;
                        dm.req   <= 1'b1;
                        dm.we    <= req_we;
                        dm.addr  <= {req_addr[DW-1:2], 2'b00};
                        dm.be    <= be;
                        dm.wdata <= wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (dm.gnt) begin
                        dm.req <= 1'b0;
                        dm.we  <= 1'b0;
                        if (we_q) begin
                            state   <= DONE;
                            st_done <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dm.rvalid) begin
                        state       <= DONE;
                        ld_valid    <= 1'b1;
                        ld_data_raw <= dm.rdata >> {off_q, 3'b000};
                        ld_width    <= width_q;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if with a randomised memory responder.
module tb_lsu_mem_if;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_width = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        lsu_busy;
    logic        ld_valid;
    logic [31:0] ld_data_raw;
    logic [2:0]  ld_width;
    logic        st_done;
    logic        misalign;

    always #5 clk = ~clk;

    lsu_mem_if_if dm();

    bit          auto_mem = 1'b1;
    logic        a_gnt = 1'b0, a_rvalid = 1'b0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] a_rdata = '0, m_rdata = '0;

    assign dm.gnt    = auto_mem ? a_gnt    : m_gnt;
    assign dm.rvalid = auto_mem ? a_rvalid : m_rvalid;
    assign dm.rdata  = auto_mem ? a_rdata  : m_rdata;

    lsu_mem_if dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .lsu_busy   (lsu_busy),
        .ld_valid   (ld_valid),
        .ld_data_raw(ld_data_raw),
        .ld_width   (ld_width),
        .st_done    (st_done),
        .misalign   (misalign),
        .dm         (dm)
    );

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [2:0]  width;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    logic [31:0] mem_q[$];
    int          errors = 0;
    int          checks = 0;
    int          gnt_dly = 0;
    int          rv_dly = 0;
    bit          inj_en = 1'b0;
    logic [31:0] last_ld = '0;
    logic [2:0]  last_w = 3'b000;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sizes, lane masks and shifts from plain arithmetic.
    task automatic model(input logic we, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, output bit mis,
                         output bus_t b, output exp_t e);
        int size;
        int off;
        size = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
        mis  = (w[1:0] == 2'b01 && a[0]) || (w == 3'b010 && a[1:0] != 2'b00);
        off  = int'(a[1:0]);
        if (mis) off = off - (off % size);
        b.we   = we;
        b.addr = a & 32'hFFFF_FFFC;
        b.be   = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++)
            b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        e.data  = rd >> (8 * off);
        e.width = w;
        if (TRAP && mis) e.kind = 2;
        else if (we)     e.kind = 1;
        else             e.kind = 0;
    endtask

    task automatic do_op(input logic we, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int gd, input int rdl);
        bit   mis;
        bit   done;
        bus_t b;
        exp_t e;
        int   lat, nreq, blo, exp_lat;
        model(we, w, a, wd, rd, mis, b, e);
        gnt_dly = gd;
        rv_dly  = rdl;
        exp_q.push_back(e);
        if (!(TRAP && mis)) begin
            bus_q.push_back(b);
            if (!we) mem_q.push_back(rd);
        end
        exp_lat = (TRAP && mis) ? 1 : we ? 2 + gd : 3 + gd + rdl;
        req_valid = 1'b1;
        req_we    = we;
        req_width = w;
        req_addr  = a;
        req_wdata = wd;
        #1 chk("busy_cycle0", lsu_busy, 1);
        lat  = 0;
        nreq = 0;
        blo  = 0;
        done = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (ld_valid || st_done || misalign) begin
                done = 1'b1;
            end else begin
                if (lat == 1 && !(TRAP && mis))
                    chk("req_next_cycle", dm.req, 1);
                nreq += int'(dm.req);
                if (!lsu_busy) blo++;
                req_valid = 1'($urandom);
                req_we    = 1'($urandom);
                req_width = 3'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
        end
        chk("done_in_time", done, 1);
        chk("latency", lat, exp_lat);
        chk("req_cycles", nreq, (TRAP && mis) ? 0 : gd + 1);
        chk("busy_gap", blo, 0);
    endtask

    task automatic go_idle(input int n);
        req_valid = 1'b0;
        #1 chk("busy_idle", lsu_busy, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_dm_req", dm.req, 0);
        chk("rst_dm_we", dm.we, 0);
        chk("rst_dm_addr", dm.addr, 0);
        chk("rst_dm_be", dm.be, 0);
        chk("rst_dm_wdata", dm.wdata, 0);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_st_done", st_done, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_ld_data", ld_data_raw, 0);
        chk("rst_ld_width", ld_width, 0);
        chk("rst_busy", lsu_busy, 0);
    endtask

    // Memory responder: grant after gnt_dly, rvalid rv_dly cycles after grant.
    initial begin
        int          gcnt;
        int          rcnt;
        bit          rd_pend;
        logic [31:0] rdv;
        bus_t        b;
        gcnt    = 0;
        rcnt    = 0;
        rd_pend = 1'b0;
        rdv     = '0;
        forever begin
            @(posedge clk);
            #1;
            a_gnt    = 1'b0;
            a_rvalid = 1'b0;
            if (rst || !auto_mem) begin
                rd_pend = 1'b0;
                gcnt    = 0;
            end else if (rd_pend) begin
                if (rcnt >= rv_dly) begin
                    a_rvalid = 1'b1;
                    a_rdata  = rdv;
                    rd_pend  = 1'b0;
                end else begin
                    rcnt++;
                end
            end else begin
                if (inj_en && $urandom_range(0, 3) == 0) begin
                    a_rvalid = 1'b1;
                    a_rdata  = $urandom;
                end
                if (dm.req) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dm_req: got req=1 expected 0");
                    end else begin
                        b = bus_q[0];
                        chk("dm_we", dm.we, b.we);
                        chk("dm_addr", dm.addr, b.addr);
                        chk("dm_be", dm.be, b.be);
                        chk("dm_wdata", dm.wdata, b.wdata);
                        if (gcnt >= gnt_dly) begin
                            a_gnt = 1'b1;
                            gcnt  = 0;
                            void'(bus_q.pop_front());
                            if (!b.we) begin
                                rd_pend = 1'b1;
                                rcnt    = 0;
                                rdv     = mem_q.size() ? mem_q.pop_front() : '0;
                            end
                        end else begin
                            gcnt++;
                        end
                    end
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every result pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_ld = '0;
            last_w  = 3'b000;
        end else if (ld_valid || st_done || misalign) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got ld=%b st=%b mis=%b expected none",
                         ld_valid, st_done, misalign);
            end else begin
                e = exp_q.pop_front();
                chk("one_pulse",
                    int'(ld_valid) + int'(st_done) + int'(misalign), 1);
                chk("kind", ld_valid ? 0 : st_done ? 1 : 2, e.kind);
                if (ld_valid) begin
                    chk("ld_data", ld_data_raw, e.data);
                    chk("ld_width", ld_width, e.width);
                    last_ld = e.data;
                    last_w  = e.width;
                end else begin
                    chk("ld_data_hold", ld_data_raw, last_ld);
                    chk("ld_width_hold", ld_width, last_w);
                end
            end
        end
    end

    logic [2:0] wtab [8];

    initial begin
        logic        we;
        logic [2:0]  w;
        logic [31:0] a;
        wtab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                 3'b011, 3'b110, 3'b111};
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'hAB112233, 0, 0);
        go_idle(1);
        do_op(1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 2, 0);
        go_idle(1);
        inj_en = 1'b1;
        do_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 3);
        go_idle(1);
        do_op(1'b0, 3'b010, 32'h301, 32'h0, 32'hCAFEF00D, 0, 0);
        go_idle(1);
        do_op(1'b1, 3'b000, 32'h401, 32'h000000C3, 32'h0, 0, 0);
        do_op(1'b0, 3'b101, 32'h402, 32'h0, 32'h8001_7FFE, 0, 0);
        go_idle(1);

        auto_mem  = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_width = 3'b010;
        req_addr  = 32'h300;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        m_gnt     = 1'b1;
        @(posedge clk);
        #1;
        m_gnt = 1'b0;
        chk("busy_in_wait", lsu_busy, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEADBEEF;
        repeat (3) begin
            @(posedge clk);
            #1;
            m_rvalid = 1'b0;
            chk("no_ld_after_rst", ld_valid, 0);
            chk("idle_after_rst", lsu_busy, 0);
        end
        auto_mem = 1'b1;

        repeat (300) begin
            we = 1'($urandom);
            w  = wtab[$urandom_range(0, 7)];
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_op(we, w, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) go_idle($urandom_range(0, 2));
        end
        go_idle(3);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store unit memory interface for the RV32 datapath MEM stage. It accepts one load or store per transaction from the pipeline and drives a request/grant/response handshake to data memory. It generates byte enables and replicated write data, stalls the pipeline until completion, and returns right-aligned raw load data with its funct3 width to the downstream load sign/zero-extension filter.

## Interface
- DW, 32, data/address width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  pipeline has a memory operation this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  3  funct3: Byte 000, Half 001, Word 010, UByte 100, UHalf 101.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- lsu_busy  out  1  pipeline stall request.
- ld_valid  out  1  one-cycle pulse: ld_data_raw/ld_width valid.
- ld_data_raw  out  32  loaded word shifted right by the byte offset, zero-filled above.
- ld_width  out  3  latched req_width of the completed load.
- st_done  out  1  one-cycle pulse: store accepted by memory.
- misalign  out  1  one-cycle pulse: misaligned access rejected (see Configuration).
- dm_req  out  1  memory request, held until dm_gnt.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word address {req_addr[31:2], 2'b00}.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated write data.
- dm_gnt  in  1  memory accepted the request this cycle.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  32  read data, word-aligned.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE/DONE with req_valid=1: latch we/width/addr/wdata and go to REQ. Otherwise DONE goes to IDLE.
- REQ: dm_req=1. On dm_gnt, a store goes to DONE with st_done=1, and a load goes to WAIT. With no grant, stay in REQ with all dm_* outputs stable.
- WAIT: dm_req=0. On dm_rvalid, capture ld_data_raw = dm_rdata >> (8*addr[1:0]) and go to DONE with ld_valid=1. dm_rvalid is ignored in every state other than WAIT.
- lsu_busy = (req_valid & (IDLE|DONE)) | REQ | WAIT. It is combinational, so the stall begins in the same cycle as req_valid.
- Byte enables:
  - Byte/UByte: 4'b0001 << addr[1:0].
  - Half/UHalf: 4'b0011 << {addr[1],1'b0}.
  - Word and the unused codes 011/110/111: 4'b1111.
- Write data: Byte {4{wdata[7:0]}}; Half {2{wdata[15:0]}}; Word wdata.
- Misaligned means Half/UHalf with addr[0]=1, or Word with addr[1:0]≠0.
- Reset (any time, including mid-transaction): state IDLE, and dm_req, dm_we, ld_valid, st_done, misalign go to 0. dm_addr, dm_be, dm_wdata, ld_data_raw go to 0 and ld_width to 000. The outstanding transaction is abandoned. A dm_rvalid arriving after reset is ignored.

## Timing
- Load, zero-wait memory: cycle0 req_valid (busy=1); cycle1 REQ with gnt; cycle2 WAIT with rvalid; cycle3 DONE with ld_valid=1, busy=0. Load latency is 3 cycles.
- Store: cycle0 request; cycle1 REQ with gnt; cycle2 DONE with st_done=1. Store latency is 2 cycles.
- Each cycle without grant or without rvalid adds exactly one cycle.
- Back-to-back: a req_valid seen in DONE is latched in that cycle, giving REQ on the next cycle.
- ld_data_raw and ld_width hold their values until the next load completes.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a misaligned request in IDLE/DONE issues no dm_req. The block goes to DONE with misalign=1 and ld_valid=0/st_done=0. busy=1 for that one cycle.
- Undefined: misalign is tied to 0. The offending low address bits are cleared to natural alignment (Half: addr[0]=0; Word: addr[1:0]=0) and the access proceeds normally.

## Test plan
- LB at 0x103, dm_rdata=0xAB112233, zero-wait memory -> dm_be=1000, ld_valid in cycle3, ld_data_raw=0x000000AB, ld_width=000.
- SH at 0x202, wdata=0x0000BEEF, dm_gnt delayed 2 cycles -> dm_req held 3 cycles, dm_addr=0x200, dm_be=1100, dm_wdata=0xBEEFBEEF, st_done in cycle4.
- LW at 0x300, rvalid delayed 3 cycles -> busy high cycles 0–5, ld_data_raw=dm_rdata in cycle6. An rvalid pulse injected during REQ is ignored.
- LW at 0x301 -> with LSU_MISALIGN_TRAP_EN: misalign pulse in cycle1 and dm_req never asserted. Without it: dm_addr=0x300, dm_be=1111, normal completion.
- Store then load issued back-to-back (req_valid in DONE) -> second REQ in the cycle after DONE, with no idle cycle.
- rst asserted during WAIT, with rvalid arriving after rst deasserts -> all outputs 0, state IDLE, and no ld_valid pulse.
